// File: rtl/lcd_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads feed a credit-limited prefetch FIFO
// and have priority; host pixel writes get a slot at least every STARVE_LIM+1 grants.
module lcd_fb_arbiter #(
  parameter int FB_WORDS   = 130560,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK_SYS,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]   STARVE_C  = ST_W'(STARVE_LIM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [ADDR_W-1:0] scan_addr;
  logic [ST_W-1:0]   starve_cnt;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [RD_LAT-1:0] rd_tag;
  logic              underrun_q;

  logic scan_req;
  logic rd_gnt;
  logic wr_gnt;
  logic ret_valid;
  logic push;
  logic pop;

  // Credit check: every read in flight already owns a FIFO slot, so returns never overflow.
  always_comb begin
    scan_req  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C;
    rd_gnt    = rst && !frame_start && scan_req && (!wr_valid || starve_cnt < STARVE_C);
    wr_gnt    = rst && wr_valid && !rd_gnt;
    ret_valid = rd_tag[RD_LAT-1];
    push      = ret_valid && !frame_start;
    pop       = pix_pop && pix_valid && !frame_start;
  end

  assign pix_valid = (fifo_cnt != '0);
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign wr_ready  = wr_gnt;
  assign underrun  = underrun_q;

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      scan_addr  <= '0;
      starve_cnt <= '0;
    end else begin
      mem_en <= rd_gnt || wr_gnt;
      mem_we <= wr_gnt;
      if (rd_gnt) begin
        mem_addr <= scan_addr;
      end else if (wr_gnt) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      if (frame_start) begin
        scan_addr <= '0;
      end else if (rd_gnt) begin
        scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + ADDR_W'(1);
      end

      if (frame_start || !wr_valid || wr_gnt) begin
        starve_cnt <= '0;
      end else if (rd_gnt && starve_cnt < STARVE_C) begin
        starve_cnt <= starve_cnt + ST_W'(1);
      end
    end
  end

  // Tags follow the registered read enable so the tail lines up with mem_rdata.
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      rd_tag   <= '0;
      inflight <= '0;
    end else if (frame_start) begin
      rd_tag   <= '0;
      inflight <= '0;
    end else begin
      rd_tag[0] <= mem_en && !mem_we;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_tag[i] <= rd_tag[i-1];
      end
      if (rd_gnt && !ret_valid) begin
        inflight <= inflight + CNT_W'(1);
      end else if (ret_valid && !rd_gnt) begin
        inflight <= inflight - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= pix_pop && !pix_valid && !frame_start;
      if (frame_start) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= mem_rdata;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          fifo_cnt <= fifo_cnt + CNT_W'(1);
        end else if (pop && !push) begin
          fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/lcd_fb_arbiter.md
# lcd_fb_arbiter

Single-port framebuffer arbiter and scanout prefetcher for the RGB LCD path, clocked by CLK_SYS (90 MHz). It shares one synchronous BSRAM port between two requesters: the display scanout, which has priority, and a host pixel writer. Scanout reads go through a small prefetch FIFO, so the pixel-rate consumer (the LCD timing generator, popping once per CLK_PIX period) never waits on memory. A starvation guard gives the writer a memory slot at a bounded interval.

## Interface
Parameters:
- FB_WORDS, 130560: framebuffer size in pixels (480×272); scanout address wraps at FB_WORDS-1.
- ADDR_W, 17: memory address width.
- DATA_W, 16: pixel width (RGB565).
- FIFO_DEPTH, 8: prefetch FIFO depth; power of two, ≥ RD_LAT+2.
- RD_LAT, 2: memory read latency in cycles, from the mem_en edge to the mem_rdata edge.
- STARVE_LIM, 4: maximum consecutive scanout grants while wr_valid is pending.

Ports:
- CLK_SYS in 1: system clock.
- rst in 1: reset, asynchronous, active-low.
- frame_start in 1: single-cycle pulse at the start of each frame. It restarts scanout at address 0 and flushes the prefetch.
- pix_pop in 1: consumer strobe, one pixel per assertion.
- pix_data out DATA_W: FIFO head pixel.
- pix_valid out 1: FIFO is not empty.
- underrun out 1: one-cycle pulse when pix_pop arrives while pix_valid=0.
- wr_valid in 1: host write request.
- wr_ready out 1: write accepted this cycle.
- wr_addr in ADDR_W: host write address.
- wr_data in DATA_W: host write data.
- mem_en out 1: registered memory enable.
- mem_we out 1: registered write enable.
- mem_addr out ADDR_W: registered memory address.
- mem_wdata out DATA_W: registered write data.
- mem_rdata in DATA_W: read data, valid RD_LAT cycles after a read.

## Operation
- **Memory port:** one memory access per cycle at most. mem_* are registered from the grant decision of the previous cycle.
- **Scanout request (scan_req):** asserted when FIFO occupancy + reads in flight < FIFO_DEPTH. This credit scheme guarantees that returned data never overflows the FIFO.
- **Arbitration:**
  - Grant the read when scan_req && (!wr_valid || starve_cnt < STARVE_LIM).
  - Otherwise grant the write if wr_valid.
  - Otherwise idle: mem_en=0 the next cycle.
- **starve_cnt:**
  - Increments on each read grant while wr_valid=1.
  - Clears on a write grant or whenever wr_valid=0.
  - Saturates at STARVE_LIM.
- **Writer handshake:**
  - wr_ready is combinational and equals the write grant.
  - A transfer occurs on wr_valid && wr_ready.
  - The host holds wr_valid, wr_addr and wr_data stable until the transfer.
  - wr_addr ≥ FB_WORDS is passed through unchecked.
- **Scan address:** increments on each read grant and wraps from FB_WORDS-1 to 0.
- **Read-return tracking:** a valid shift register of length RD_LAT. A set bit at the tail pushes mem_rdata into the FIFO.
- **frame_start has priority over everything in its cycle:**
  - scan_addr←0, FIFO emptied, all in-flight tags cleared (their data is discarded on arrival), in-flight count←0, starve_cnt←0.
  - No read grant is issued in that cycle; a write grant is still allowed.
  - A coincident pix_pop is ignored and produces no underrun.
- **FIFO:** simultaneous push and pop is legal; occupancy is unchanged. A pop while empty changes nothing and pulses underrun.
- **Reset:** every register is cleared. Outputs during reset: pix_data=0, pix_valid=0, underrun=0, wr_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - In-flight reads are dropped.
  - The first scan after reset starts at address 0, without needing a frame_start.

## Timing
- Read path: a grant in cycle t gives mem_en=1, mem_we=0 in cycle t+1. Data is captured at cycle t+1+RD_LAT and pix_valid is high in cycle t+2+RD_LAT.
- frame_start sampled at edge 0 → read of address 0 issued at edge 1 (first grant) → pix_valid=1 after edge 2+RD_LAT (cycle 4 with RD_LAT=2).
- Sustained read bandwidth is one word per cycle, which is ≫ the pixel rate (1 per 10 cycles). The FIFO refills within RD_LAT+1 cycles of a pop.
- Worst-case writer wait with scanout saturated: STARVE_LIM+1 cycles from wr_valid to wr_ready.
- Worst-case scanout slot loss: 1 cycle per STARVE_LIM+1. No underrun is possible at the pixel rate after initial fill.

## Test plan
- **Reset/fill:**
  - Stimulus: release rst with a memory model returning data=addr.
  - Required: all outputs 0 during reset; mem reads at addresses 0..7 back-to-back; pix_valid=1 at cycle 4; FIFO holds 0..7 and stalls (no mem_en) while full.
- **Pixel-rate drain:**
  - Stimulus: pix_pop every 10 cycles for 2000 pops.
  - Required: pix_data sequence 0,1,2…; underrun never asserted.
- **Write starvation:**
  - Stimulus: wr_valid held high with addr 0x100 while scanout is saturated (pix_pop every cycle).
  - Required: wr_ready within 5 cycles; mem_we=1, mem_addr=0x100 the next cycle; then exactly 4 reads between successive writes.
- **frame_start mid-flight:**
  - Stimulus: pulse frame_start while 2 reads are in flight and the FIFO holds 5 words.
  - Required: pix_valid=0 the next cycle; stale data discarded; the next popped pixels are 0,1,2.
- **Wrap-around:**
  - Stimulus: FB_WORDS=16 and continuous pops.
  - Required: pixel sequence …14,15,0,1 with no gap.
- **Underrun and async reset:**
  - Stimulus: pix_pop on an empty FIFO, then assert rst mid-burst.
  - Required: underrun is a 1-cycle pulse; all outputs go to 0 immediately on rst low.
